// File: rtl/lifo_stack.sv
// lifo_stack: parametrised LIFO stack with push, pop, replace (push+pop),
// pass-through on empty, combinational top-of-stack view, occupancy count
// and sticky overflow/underflow flags.
module lifo_stack #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              push,
  input  logic              pop,
  input  logic              clr_err,
  input  logic [DATA_W-1:0] dataInput,
  output logic [DATA_W-1:0] dataOutput,
  output logic              pop_valid,
  output logic [DATA_W-1:0] top,
  output logic [CNT_W-1:0]  sp,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [CNT_W-1:0]  sp_q, sp_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              pv_q, pv_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic              memWe;
  logic [AW-1:0]     memAddr;
  logic              isFull;
  logic              isEmpty;
  logic [AW-1:0]     topIdx;
  logic [AW-1:0]     freeIdx;
  logic [DATA_W-1:0] topData;

  // Status and top-of-stack are pure decodes of the registered pointer.
  // The address arithmetic is done in AW bits: when full, sp truncates to 0
  // for power-of-two depths and the decrement wraps to DEPTH-1 as wanted.
  assign isFull  = (sp_q == DEPTH_C);
  assign isEmpty = (sp_q == '0);
  assign freeIdx = AW'(sp_q);
  assign topIdx  = AW'(sp_q) - AW'(1);
  assign topData = isEmpty ? '0 : mem_q[topIdx];

  // Next-state decode: error clearing is applied first so that an error
  // raised in the same cycle overrides it.
  always_comb begin
    sp_d    = sp_q;
    dout_d  = dout_q;
    pv_d    = 1'b0;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    memWe   = 1'b0;
    memAddr = freeIdx;
    if (en) begin
      if (clr_err) begin
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end
      if (push && !pop) begin
        if (isFull) begin
          ovf_d = 1'b1;
        end else begin
          memWe   = 1'b1;
          memAddr = freeIdx;
          sp_d    = sp_q + CNT_W'(1);
        end
      end else if (pop && !push) begin
        if (isEmpty) begin
          udf_d = 1'b1;
        end else begin
          dout_d = mem_q[topIdx];
          sp_d   = sp_q - CNT_W'(1);
          pv_d   = 1'b1;
        end
      end else if (push && pop) begin
        pv_d = 1'b1;
        if (isEmpty) begin
          dout_d = dataInput;
        end else begin
          dout_d  = mem_q[topIdx];
          memWe   = 1'b1;
          memAddr = topIdx;
        end
      end
    end
  end

  // Control state registers, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q   <= '0;
      dout_q <= '0;
      pv_q   <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      dout_q <= dout_d;
      pv_q   <= pv_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  // Storage array is deliberately not reset; sp=0 makes stale data unreachable.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem_q[memAddr] <= dataInput;
    end
  end

  assign dataOutput = dout_q;
  assign pop_valid  = pv_q;
  assign top        = topData;
  assign sp         = sp_q;
  assign full       = isFull;
  assign empty      = isEmpty;
  assign overflow   = ovf_q;
  assign underflow  = udf_q;

endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed scenarios plus randomized traffic for lifo_stack,
// checked against a queue-based reference model.
module tb_lifo_stack;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst;
  logic              en;
  logic              push;
  logic              pop;
  logic              clr_err;
  logic [DATA_W-1:0] dataInput;
  logic [DATA_W-1:0] dataOutput;
  logic              pop_valid;
  logic [DATA_W-1:0] top;
  logic [CNT_W-1:0]  sp;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;

  lifo_stack #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .push      (push),
    .pop       (pop),
    .clr_err   (clr_err),
    .dataInput (dataInput),
    .dataOutput(dataOutput),
    .pop_valid (pop_valid),
    .top       (top),
    .sp        (sp),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectorCount = 0;
  int missCount   = 0;

  logic [DATA_W-1:0] model[$];
  logic [DATA_W-1:0] expDout;
  logic              expPv;
  logic              expOvf;
  logic              expUdf;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    model.delete();
    expDout = '0;
    expPv   = 1'b0;
    expOvf  = 1'b0;
    expUdf  = 1'b0;
  endtask

  task automatic modelStep(input logic e, input logic p, input logic q,
                           input logic c, input logic [DATA_W-1:0] d);
    expPv = 1'b0;
    if (e) begin
      if (c) begin
        expOvf = 1'b0;
        expUdf = 1'b0;
      end
      if (p && !q) begin
        if (model.size() == DEPTH) expOvf = 1'b1;
        else model.push_back(d);
      end else if (q && !p) begin
        if (model.size() == 0) expUdf = 1'b1;
        else begin
          expDout = model.pop_back();
          expPv   = 1'b1;
        end
      end else if (p && q) begin
        expPv = 1'b1;
        if (model.size() == 0) expDout = d;
        else begin
          expDout = model.pop_back();
          model.push_back(d);
        end
      end
    end
  endtask

  task automatic checkAll(input string ctx);
    logic [DATA_W-1:0] expTop;
    expTop = (model.size() > 0) ? model[$] : '0;
    checkOutput({ctx, ".sp"},         32'(sp),         32'(model.size()));
    checkOutput({ctx, ".top"},        32'(top),        32'(expTop));
    checkOutput({ctx, ".full"},       32'(full),       32'(model.size() == DEPTH));
    checkOutput({ctx, ".empty"},      32'(empty),      32'(model.size() == 0));
    checkOutput({ctx, ".dataOutput"}, 32'(dataOutput), 32'(expDout));
    checkOutput({ctx, ".pop_valid"},  32'(pop_valid),  32'(expPv));
    checkOutput({ctx, ".overflow"},   32'(overflow),   32'(expOvf));
    checkOutput({ctx, ".underflow"},  32'(underflow),  32'(expUdf));
  endtask

  task automatic applyStimulus(input logic e, input logic p, input logic q,
                               input logic c, input logic [DATA_W-1:0] d,
                               input string ctx);
    en        = e;
    push      = p;
    pop       = q;
    clr_err   = c;
    dataInput = d;
    @(posedge clk);
    modelStep(e, p, q, c, d);
    #1;
    checkAll(ctx);
  endtask

  // Reset raised between edges; outputs must clear before any clock edge.
  task automatic resetMid(input string ctx);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkAll(ctx);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    clr_err   = 1'b0;
    dataInput = '0;
    modelReset();
    #1;
    checkAll("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Underflow from empty, disabled pop, error-vs-clear priority.
    applyStimulus(1, 0, 1, 0, 4'h0, "popEmpty");
    applyStimulus(0, 0, 1, 0, 4'h0, "popDisabled");
    applyStimulus(0, 0, 0, 1, 4'h0, "clrDisabled");
    applyStimulus(1, 0, 1, 1, 4'h0, "errAndClr");
    applyStimulus(1, 0, 0, 1, 4'h0, "clrUdf");

    // Pass-through on empty stack.
    applyStimulus(1, 1, 1, 0, 4'hE, "passThru");

    // Basic push/pop.
    applyStimulus(1, 1, 0, 0, 4'h7, "push7");
    applyStimulus(1, 1, 0, 0, 4'h8, "push8");
    applyStimulus(1, 0, 1, 0, 4'h0, "pop8");
    applyStimulus(1, 0, 0, 0, 4'h0, "idle");
    applyStimulus(1, 0, 1, 0, 4'h0, "pop7");

    // Fill, overflow, clear, replace on full.
    applyStimulus(1, 1, 0, 0, 4'hA, "pushA");
    applyStimulus(1, 1, 0, 0, 4'hB, "pushB");
    applyStimulus(1, 1, 0, 0, 4'hC, "pushC");
    applyStimulus(1, 1, 0, 0, 4'hD, "pushD");
    applyStimulus(1, 1, 0, 0, 4'hE, "pushFull");
    applyStimulus(1, 0, 0, 1, 4'h0, "clrOvf");
    applyStimulus(1, 1, 1, 0, 4'h3, "replaceFull");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 1, 0, 4'h0, "drain");

    // Replace on partial stack.
    applyStimulus(1, 1, 0, 0, 4'h5, "push5");
    applyStimulus(1, 1, 0, 0, 4'h6, "push6");
    applyStimulus(1, 1, 1, 0, 4'h9, "replace9");
    applyStimulus(1, 0, 1, 0, 4'h0, "pop9");
    applyStimulus(1, 0, 1, 0, 4'h0, "pop5");

    // Asynchronous reset mid-sequence with sp=3, dataOutput=4.
    applyStimulus(1, 1, 0, 0, 4'h1, "push1");
    applyStimulus(1, 1, 0, 0, 4'h2, "push2");
    applyStimulus(1, 1, 0, 0, 4'h3, "push3");
    applyStimulus(1, 1, 0, 0, 4'h4, "push4");
    applyStimulus(1, 0, 1, 0, 4'h0, "pop4");
    resetMid("asyncRst");
    applyStimulus(1, 1, 0, 0, 4'h2, "pushAfterRst");

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        resetMid("rndRst");
      end else begin
        applyStimulus(1'($urandom_range(0, 7) != 0),
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 11) == 0),
                      DATA_W'($urandom_range(0, 15)),
                      "random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
